que_drain_ctrl: RTL



---
 rtl/que_drain_pkg.sv | 27 ++
 rtl/que_key_mixer.sv | 27 ++
 rtl/que_drain_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/que_drain_pkg.sv
// que_drain_pkg: shared types and helpers for the FIFO drain / key-mix path.
//   state_t    - drain controller state encoding
//   QUE_DATA_W - default data/key width
//   rotl       - rotate-left of a QUE_DATA_W word
package que_drain_pkg;

    localparam int unsigned QUE_DATA_W = 32;
    localparam int unsigned QUE_ROT_W  = $clog2(QUE_DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND,
        CSUM,
        DONE
    } state_t;

    function automatic logic [QUE_DATA_W-1:0] rotl(
        input logic [QUE_DATA_W-1:0] v,
        input logic [QUE_ROT_W-1:0]  amt
    );
        // A shift by the full width yields zero, so amt == 0 is a plain copy.
        return (v << amt) | (v >> (QUE_DATA_W - 32'(amt)));
    endfunction

endpackage

// File: rtl/que_key_mixer.sv
// que_key_mixer: combinational rotate-and-XOR of a cipher key with a data word.
// Shared by the encrypt (writer) and decrypt (drain) sides.
// Ports:
//   i_key  [DATA_W]       - cipher key
//   i_amt  [log2(DATA_W)] - rotate-left amount (word index modulo DATA_W)
//   i_data [DATA_W]       - data word
//   o_data [DATA_W]       - i_data ^ rotl(i_key, i_amt)
module que_key_mixer
    import que_drain_pkg::*;
#(
    parameter int unsigned DATA_W = QUE_DATA_W
) (
    input  logic [DATA_W-1:0]         i_key,
    input  logic [$clog2(DATA_W)-1:0] i_amt,
    input  logic [DATA_W-1:0]         i_data,
    output logic [DATA_W-1:0]         o_data
);

    generate
        if (DATA_W == QUE_DATA_W) begin : g_pkg_rot
            assign o_data = i_data ^ rotl(i_key, i_amt);
        end else begin : g_generic_rot
            assign o_data = i_data ^ ((i_key << i_amt) | (i_key >> (DATA_W - 32'(i_amt))));
        end
    endgenerate

endmodule

// File: rtl/que_drain_ctrl.sv
// que_drain_ctrl: drains a burst of words from the encryption FIFO, decrypts
// each with a per-word rotated key and streams them out on valid/ready.
// Optional feature macro: QUE_DRAIN_CHECKSUM_EN appends an XOR checksum
// trailer (carrying Out_Last) to every burst.
// Ports:
//   Clk, reset            - clock, synchronous active-high reset
//   Start                 - begin a burst (sampled in IDLE only)
//   Burst_Len [LEN_W]     - words to drain; 0 = until QUE_Last
//   Cipher_Key [DATA_W]   - key, latched on accepted Start
//   QUE_Data_Out, QUE_Empty, QUE_Last - FIFO read side inputs
//   Cen, QUE_Read_Write   - FIFO read strobe / direction (always read)
//   Out_Data, Out_Valid, Out_Ready, Out_Last - output stream
//   Busy, Done            - status: not idle / one-cycle end-of-burst pulse
module que_drain_ctrl
    import que_drain_pkg::*;
#(
    parameter int unsigned DATA_W = QUE_DATA_W,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [LEN_W-1:0]  Burst_Len,
    input  logic [DATA_W-1:0] Cipher_Key,
    input  logic [DATA_W-1:0] QUE_Data_Out,
    input  logic              QUE_Empty,
    input  logic              QUE_Last,
    output logic              Cen,
    output logic              QUE_Read_Write,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Out_Last,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned IDX_W = LEN_W + 1;
    localparam int unsigned SH_W  = $clog2(DATA_W);

    state_t              r_state;
    logic [DATA_W-1:0]   r_key;
    logic [LEN_W-1:0]    r_len;
    logic [IDX_W-1:0]    r_idx;
    logic                r_final;
`ifdef QUE_DRAIN_CHECKSUM_EN
    logic [DATA_W-1:0]   r_csum;
`endif

    logic [SH_W-1:0]     w_amt;
    logic [DATA_W-1:0]   w_plain;
    logic                w_final;

    assign Cen            = (r_state == REQ) && !QUE_Empty;
    assign QUE_Read_Write = 1'b0;

    assign w_amt   = SH_W'(r_idx);
    assign w_final = (r_len != '0) ? (r_idx == (IDX_W'(r_len) - IDX_W'(1))) : QUE_Last;

    que_key_mixer #(
        .DATA_W(DATA_W)
    ) u_key_mixer (
        .i_key (r_key),
        .i_amt (w_amt),
        .i_data(QUE_Data_Out),
        .o_data(w_plain)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_key     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_final   <= 1'b0;
`ifdef QUE_DRAIN_CHECKSUM_EN
            r_csum    <= '0;
`endif
            Out_Data  <= '0;
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_key   <= Cipher_Key;
                        r_len   <= Burst_Len;
                        r_idx   <= '0;
`ifdef QUE_DRAIN_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                        Busy    <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (!QUE_Empty) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    Out_Data  <= w_plain;
                    Out_Valid <= 1'b1;
                    r_final   <= w_final;
`ifdef QUE_DRAIN_CHECKSUM_EN
                    Out_Last  <= 1'b0;
`else
                    Out_Last  <= w_final;
`endif
                    r_state   <= SEND;
                end
                SEND: begin
                    if (Out_Ready) begin
                        r_idx <= r_idx + IDX_W'(1);
`ifdef QUE_DRAIN_CHECKSUM_EN
                        r_csum <= r_csum ^ Out_Data;
`endif
                        if (r_final) begin
`ifdef QUE_DRAIN_CHECKSUM_EN
                            // Trailer is loaded on the final data handshake edge;
                            // Out_Valid stays high straight into CSUM.
                            Out_Data  <= r_csum ^ Out_Data;
                            Out_Last  <= 1'b1;
                            r_state   <= CSUM;
`else
                            Out_Valid <= 1'b0;
                            Out_Last  <= 1'b0;
                            Done      <= 1'b1;
                            r_state   <= DONE;
`endif
                        end else begin
                            Out_Valid <= 1'b0;
                            r_state   <= REQ;
                        end
                    end
                end
`ifdef QUE_DRAIN_CHECKSUM_EN
                CSUM: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        Out_Last  <= 1'b0;
                        Done      <= 1'b1;
                        r_state   <= DONE;
                    end
                end
`endif
                DONE: begin
                    Busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
